fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core; sits directly upstream of the combinational program memory. Owns the program counter, drives the byte address into program memory, captures the returned 32-bit little-endian instruction word with its PC, and delivers both to decode through a valid/ready handshake backed by a small FIFO. Supports a single-cycle redirect (branch/jump) that flushes everything in flight.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/fetch_unit_if.sv | 21 ++
 rtl/fetch_fifo.sv | 44 ++++
 rtl/fetch_unit.sv | 43 ++++
 tb/tb_fetch_unit.sv | 137 +++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the fetch-entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSN_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: program-memory, redirect and decode handshake signals of the fetch stage
interface fetch_unit_if;
  import riscv_pkg::*;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_ins;
  logic [XLEN-1:0] out_pc;
  logic misalign_err;
  modport master (
    output imem_addr, out_valid, out_ins, out_pc, misalign_err,
    input imem_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input imem_addr, out_valid, out_ins, out_pc, misalign_err,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush; head is read straight from storage
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, fetch/redirect control and sticky misalignment flag in front of decode
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int BUF_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  fetch_unit_if.master bus
);
  logic [XLEN-1:0] pc;
  logic push, pop, full, empty;
  fetch_entry_t head;
  assign bus.imem_addr = pc;
  assign bus.out_valid = !empty;
  assign bus.out_ins = head.ins;
  assign bus.out_pc = head.pc;
  assign pop = !empty && bus.out_ready;
  assign push = !bus.redirect_valid && (!full || pop);
  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(bus.redirect_valid),
    .din('{ins: bus.imem_data, pc: pc}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      bus.misalign_err <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      if (bus.redirect_pc[1:0] != 2'b00) bus.misalign_err <= 1'b1;
    end else if (push) begin
      pc <= pc + XLEN'(INSN_BYTES);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios against a byte-pattern program memory (byte at a = {a[3:0],4'h0})
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] seq [4] = '{32'h3020_1000, 32'h7060_5040, 32'hB0A0_9080, 32'hF0E0_D0C0};
  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return {a[3:0], 4'h0};
  endfunction
  always_comb bus.imem_data = {mem_byte(bus.imem_addr + 32'd3), mem_byte(bus.imem_addr + 32'd2),
                               mem_byte(bus.imem_addr + 32'd1), mem_byte(bus.imem_addr)};
  task automatic test_reset;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(negedge clk);
    n_checks += 4;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %h want 0", bus.out_valid); end
    if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
    if (bus.out_ins !== 32'h0 || bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_outs got %h/%h want 0/0", bus.out_pc, bus.out_ins); end
    if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %h want 0", bus.misalign_err); end
    rst_n = 1'b1;
  endtask
  task automatic test_stream;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4) || bus.out_ins !== seq[i]) begin
        n_fail++;
        $display("FAIL stream[%0d] got v=%h pc=%h ins=%h want v=1 pc=%h ins=%h", i, bus.out_valid, bus.out_pc, bus.out_ins, i * 4, seq[i]);
      end
    end
  endtask
  task automatic test_backpressure;
    test_reset();
    repeat (5) @(negedge clk);
    n_checks += 2;
    if (bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_addr got %h want 8", bus.imem_addr); end
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head got v=%h pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc); end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4) || bus.out_ins !== seq[i]) begin
        n_fail++;
        $display("FAIL bp_drain[%0d] got v=%h pc=%h ins=%h want v=1 pc=%h ins=%h", i, bus.out_valid, bus.out_pc, bus.out_ins, i * 4, seq[i]);
      end
    end
  endtask
  task automatic test_redirect;
    test_reset();
    repeat (2) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h4;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_checks += 2;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble got v=%h want 0", bus.out_valid); end
    if (bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL redir_addr got %h want 4", bus.imem_addr); end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4 || bus.out_ins !== 32'h7060_5040) begin
      n_fail++;
      $display("FAIL redir_target got v=%h pc=%h ins=%h want v=1 pc=4 ins=70605040", bus.out_valid, bus.out_pc, bus.out_ins);
    end
  endtask
  task automatic test_misalign;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h9;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_checks += 2;
    if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_set got %h want 1", bus.misalign_err); end
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL mis_bubble got v=%h addr=%h want v=0 addr=8", bus.out_valid, bus.imem_addr); end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8 || bus.out_ins !== 32'hB0A0_9080) begin
      n_fail++;
      $display("FAIL mis_target got v=%h pc=%h ins=%h want v=1 pc=8 ins=b0a09080", bus.out_valid, bus.out_pc, bus.out_ins);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_sticky got %h want 1", bus.misalign_err); end
  endtask
  task automatic test_wrap;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_bubble got v=%h addr=%h want v=0 addr=fffffffc", bus.out_valid, bus.imem_addr); end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hFFFF_FFFC || bus.out_ins !== 32'hF0E0_D0C0) begin
      n_fail++;
      $display("FAIL wrap_top got v=%h pc=%h ins=%h want v=1 pc=fffffffc ins=f0e0d0c0", bus.out_valid, bus.out_pc, bus.out_ins);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_ins !== 32'h3020_1000) begin
      n_fail++;
      $display("FAIL wrap_zero got v=%h pc=%h ins=%h want v=1 pc=0 ins=30201000", bus.out_valid, bus.out_pc, bus.out_ins);
    end
  endtask
  task automatic test_async_reset;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_full got v=%h want 1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_clear got v=%h addr=%h want v=0 addr=0", bus.out_valid, bus.imem_addr); end
    if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL ar_misalign got %h want 0", bus.misalign_err); end
    @(negedge clk);
    rst_n = 1'b1;
    test_stream();
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
